// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions used by the encryption and decryption cores.
//   aes_state_t  : 4x4 byte state, indexed [column][row]; [0][0] is bits [127:120]
//                  so a 128-bit word maps column-major with w[0] = [127:96].
//   key_dir_e    : direction select for the shared key-schedule step.
//   RCON         : round constants rcon[0..9]; rcon_word() returns 0 past index 9.
//   sbox/inv_sbox: S-box and inverse S-box, computed as GF(2^8) inversion
//                  combined with the affine transform (no 256-entry tables).
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [0:3][0:3][7:0] aes_state_t;

    typedef enum logic {
        KEY_FWD = 1'b0,
        KEY_INV = 1'b1
    } key_dir_e;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [31:0] rcon_word(input logic [3:0] idx);
        return (idx < 4'd10) ? {RCON[idx], 24'h000000} : 32'h0000_0000;
    endfunction

    // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // a^254 = a^-1 for a != 0 and 0 for a == 0: product of a^2, a^4, ..., a^128.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_inv_core_if.sv
// -----------------------------------------------------------------------------
// aes_inv_core_if
// Bus between the SPI front end (master) and the decryption core (slave).
//   load       : start pulse, key/cyphertext sampled on the edge where it is 1
//   key        : 128-bit cipher key
//   cyphertext : 128-bit block to decrypt
//   done       : plaintext valid
//   plaintext  : 128-bit recovered block
// -----------------------------------------------------------------------------
interface aes_inv_core_if;
    logic         load;
    logic [127:0] key;
    logic [127:0] cyphertext;
    logic         done;
    logic [127:0] plaintext;

    modport master (output load, key, cyphertext, input done, plaintext);
    modport slave  (input load, key, cyphertext, output done, plaintext);
endinterface

// File: rtl/aes_key_step.sv
// -----------------------------------------------------------------------------
// aes_key_step
// One AES-128 key-schedule step in either direction.
//   dir_i  : KEY_FWD -> next round key, KEY_INV -> previous round key
//   rcon_i : round constant word (constant in the top byte)
//   key_i  : current round key
//   key_o  : stepped round key
// -----------------------------------------------------------------------------
module aes_key_step
    import aes_pkg::*;
(
    input  key_dir_e     dir_i,
    input  logic [31:0]  rcon_i,
    input  logic [127:0] key_i,
    output logic [127:0] key_o
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] sub_in, t;
    logic [31:0] f0, f1, f2, f3;

    assign {w0, w1, w2, w3} = key_i;

    // Both directions feed SubWord(RotWord(x)) from the last word of the
    // *older* key: forward that is w3 itself, inverse it is recovered as w3^w2.
    // Sharing the four S-boxes this way keeps a single copy.
    assign sub_in = (dir_i == KEY_INV) ? (w3 ^ w2) : w3;
    assign t      = sub_word({sub_in[23:0], sub_in[31:24]}) ^ rcon_i;

    assign f0 = w0 ^ t;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    assign key_o = (dir_i == KEY_INV) ? {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2}
                                      : {f0, f1, f2, f3};
endmodule

// File: rtl/inv_mixcolumns.sv
// -----------------------------------------------------------------------------
// inv_mixcolumns / inv_mixcolumn
// Combinational AES InvMixColumns over the whole state, one instance of
// inv_mixcolumn per column.
//   state_i / state_o : aes_state_t in and out
//   col_i / col_o     : one column (rows 0..3) in and out
// -----------------------------------------------------------------------------
module inv_mixcolumns
    import aes_pkg::*;
(
    input  aes_state_t state_i,
    output aes_state_t state_o
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        inv_mixcolumn u_col (.col_i(state_i[c]), .col_o(state_o[c]));
    end
endmodule

module inv_mixcolumn
    import aes_pkg::*;
(
    input  logic [0:3][7:0] col_i,
    output logic [0:3][7:0] col_o
);
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];

    // 09, 0b, 0d, 0e built from x, 2x, 4x, 8x.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            logic [7:0] x2, x4, x8;
            x2    = xtime(col_i[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ col_i[r];
            mb[r] = x8 ^ x2 ^ col_i[r];
            md[r] = x8 ^ x4 ^ col_i[r];
            me[r] = x8 ^ x4 ^ x2;
        end
    end

    assign col_o[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    assign col_o[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    assign col_o[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    assign col_o[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
endmodule

// File: rtl/aes_inv_core.sv
// -----------------------------------------------------------------------------
// aes_inv_core
// Iterative AES-128 decryption: forward-expands the key to rk10 (10 cycles),
// then runs the inverse cipher one round per clock while stepping the key
// schedule backwards. done rises 22 cycles after the load edge.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : aes_inv_core_if slave (load/key/cyphertext in, done/plaintext out)
// -----------------------------------------------------------------------------
module aes_inv_core
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    aes_inv_core_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_EXPAND, ST_INIT, ST_ROUND, ST_FINAL, ST_DONE
    } fsm_e;

    fsm_e         fsm_q, fsm_d;
    aes_state_t   state_q, state_d;
    logic [127:0] round_key_q, round_key_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         done_q, done_d;

    aes_state_t   sub_shift, add_key, mix_out;
    logic [127:0] key_next;
    key_dir_e     key_dir;
    logic [3:0]   rcon_idx;
    logic [31:0]  rcon_w;

    // InvShiftRows (row r rotates right by r) fused with InvSubBytes.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_shift[c][r] = inv_sbox(state_q[2'(c - r)][r]);
            end
        end
    end

    assign add_key = sub_shift ^ round_key_q;

    inv_mixcolumns u_inv_mix (.state_i(add_key), .state_o(mix_out));

    // INIT steps back from rk10 with rcon[9] (counter already 9); each ROUND
    // uses rcon[counter-1] to reach the key needed by the following round.
    assign key_dir  = (fsm_q == ST_EXPAND) ? KEY_FWD : KEY_INV;
    assign rcon_idx = (fsm_q == ST_ROUND) ? cnt_q - 4'd1 : cnt_q;
    assign rcon_w   = rcon_word(rcon_idx);

    aes_key_step u_key_step (
        .dir_i  (key_dir),
        .rcon_i (rcon_w),
        .key_i  (round_key_q),
        .key_o  (key_next)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        fsm_d       = fsm_q;
        state_d     = state_q;
        round_key_d = round_key_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;

        if (bus.load) begin
            // Accepted in any state: aborts whatever is in flight.
            fsm_d       = ST_EXPAND;
            state_d     = bus.cyphertext;
            round_key_d = bus.key;
            cnt_d       = 4'd0;
        end else begin
            unique case (fsm_q)
                ST_IDLE: ;
                ST_EXPAND: begin
                    round_key_d = key_next;
                    if (cnt_q == 4'd9) begin
                        fsm_d = ST_INIT;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ST_INIT: begin
                    state_d     = state_q ^ round_key_q;
                    round_key_d = key_next;
                    fsm_d       = ST_ROUND;
                end
                ST_ROUND: begin
                    state_d     = mix_out;
                    round_key_d = key_next;
                    if (cnt_q == 4'd1) begin
                        fsm_d = ST_FINAL;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_FINAL: begin
                    state_d = add_key;
                    fsm_d   = ST_DONE;
                end
                ST_DONE: done_d = 1'b1;
                default: fsm_d = ST_IDLE;
            endcase
        end
    end

    // done is registered one cycle behind entry to DONE so the front end sees
    // a clean flop output; plaintext is already stable by then.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: non-blocking assignments keep every register updating from
        // the pre-edge values, independent of statement order.
        if (!reset_n) begin
            fsm_q       <= ST_IDLE;
            state_q     <= '0;
            round_key_q <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            round_key_q <= round_key_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
        end
    end

    assign bus.done      = done_q;
    assign bus.plaintext = state_q;
endmodule

// File: tb/tb_aes_inv_core.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_core
// Self-checking bench for aes_inv_core: FIPS-197 vectors, restart, async reset,
// held load, and random round trips through a table-driven AES encryption model.
// -----------------------------------------------------------------------------
module tb_aes_inv_core;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_RK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    aes_inv_core_if bus ();

    aes_inv_core dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- reference model ----------------
    logic [7:0] sbox_t [256];
    logic [7:0] exp_t  [256];
    int         log_t  [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    // Log/antilog tables from generator 03, then the FIPS affine map bitwise.
    task automatic init_tables();
        logic [7:0] e, inv, s;
        logic [7:0] aff_c;
        aff_c = 8'h63;
        e = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = e;
            log_t[e] = i;
            e = e ^ xt(e);
        end
        exp_t[255] = 8'h01;
        log_t[0]   = 0;
        for (int a = 0; a < 256; a++) begin
            inv = (a == 0) ? 8'h00 : exp_t[(255 - log_t[a]) % 255];
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ aff_c[i];
            end
            sbox_t[a] = s;
        end
    endtask

    function automatic logic [127:0] f_sub(input logic [127:0] x);
        logic [127:0] y;
        for (int k = 0; k < 16; k++) y[127 - 8*k -: 8] = sbox_t[x[127 - 8*k -: 8]];
        return y;
    endfunction

    function automatic logic [127:0] f_shift(input logic [127:0] x);
        logic [127:0] y;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                y[127 - 8*(4*c + r) -: 8] = x[127 - 8*(4*((c + r) % 4) + r) -: 8];
        return y;
    endfunction

    function automatic logic [127:0] f_mix(input logic [127:0] x);
        logic [127:0] y;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = x[127 - 32*c -: 8];
            a1 = x[119 - 32*c -: 8];
            a2 = x[111 - 32*c -: 8];
            a3 = x[103 - 32*c -: 8];
            y[127 - 32*c -: 8] = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
            y[119 - 32*c -: 8] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
            y[111 - 32*c -: 8] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
            y[103 - 32*c -: 8] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
        return y;
    endfunction

    function automatic logic [127:0] tb_encrypt(input logic [127:0] key,
                                                input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] s;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]],
                       sbox_t[tmp[31:24]]} ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int n = 1; n <= 10; n++) begin
            s = f_shift(f_sub(s));
            if (n < 10) s = f_mix(s);
            s = s ^ {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
        end
        return s;
    endfunction

    // ---------------- bench helpers ----------------
    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load_vec(input logic [127:0] k, input logic [127:0] ct);
        bus.load       = 1'b1;
        bus.key        = k;
        bus.cyphertext = ct;
        tick();
        bus.load = 1'b0;
        cyc      = 0;
    endtask

    task automatic wait_done();
        while (bus.done !== 1'b1 && cyc < 200) tick();
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic         seen;
        logic [127:0] key, pt, ct;
        int           hold;

        init_tables();
        reset_n        = 1'b0;
        bus.load       = 1'b0;
        bus.key        = '0;
        bus.cyphertext = '0;
        tick();
        tick();
        check("rst_done", 128'(bus.done), 128'd0);
        check("rst_pt", bus.plaintext, 128'd0);
        reset_n = 1'b1;
        repeat (3) tick();
        check("idle_done", 128'(bus.done), 128'd0);

        // FIPS-197 C.1 with round-key peek at INIT and exact latency.
        load_vec(C1_KEY, C1_CT);
        repeat (10) tick();
        check("c1_rk10", dut.round_key_q, C1_RK);
        wait_done();
        check("c1_lat", 128'(cyc), 128'd22);
        check("c1_pt", bus.plaintext, C1_PT);
        repeat (5) tick();
        check("c1_hold_done", 128'(bus.done), 128'd1);
        check("c1_hold_pt", bus.plaintext, C1_PT);

        // Async reset while done is high: outputs clear before any edge.
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_done", 128'(bus.done), 128'd0);
        check("async_rst_pt", bus.plaintext, 128'd0);
        tick();
        reset_n = 1'b1;

        // FIPS-197 Appendix B.
        load_vec(B_KEY, B_CT);
        repeat (10) tick();
        check("b_rk10", dut.round_key_q, B_RK);
        wait_done();
        check("b_lat", 128'(cyc), 128'd22);
        check("b_pt", bus.plaintext, B_PT);

        // Restart: B, then C.1 loaded 15 cycles later; done falls on the load.
        load_vec(B_KEY, B_CT);
        check("b_load_clears_done", 128'(bus.done), 128'd0);
        seen = 1'b0;
        repeat (14) begin
            tick();
            if (bus.done === 1'b1) seen = 1'b1;
        end
        load_vec(C1_KEY, C1_CT);
        while (bus.done !== 1'b1 && cyc < 200) begin
            if (cyc < 22 && bus.done === 1'b1) seen = 1'b1;
            tick();
        end
        check("restart_no_early_done", 128'(seen), 128'd0);
        check("restart_lat", 128'(cyc), 128'd22);
        check("restart_pt", bus.plaintext, C1_PT);

        // load held for three cycles; only the last capture counts.
        bus.load       = 1'b1;
        bus.key        = rand128();
        bus.cyphertext = rand128();
        tick();
        bus.key        = rand128();
        bus.cyphertext = rand128();
        tick();
        check("held_load_done", 128'(bus.done), 128'd0);
        load_vec(B_KEY, B_CT);
        wait_done();
        check("held_lat", 128'(cyc), 128'd22);
        check("held_pt", bus.plaintext, B_PT);

        // Reset mid-run at cycle 8, no done until a new load.
        load_vec(C1_KEY, C1_CT);
        repeat (8) tick();
        #2 reset_n = 1'b0;
        #1;
        check("midrst_done", 128'(bus.done), 128'd0);
        check("midrst_pt", bus.plaintext, 128'd0);
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (bus.done !== 1'b0) seen = 1'b1;
        end
        check("midrst_stays_idle", 128'(seen), 128'd0);
        load_vec(C1_KEY, C1_CT);
        wait_done();
        check("midrst_lat", 128'(cyc), 128'd22);
        check("midrst_pt_after", bus.plaintext, C1_PT);

        // Random round trips through the model's encryption.
        for (int n = 0; n < 100; n++) begin
            key = rand128();
            pt  = rand128();
            ct  = tb_encrypt(key, pt);
            load_vec(key, ct);
            check("rt_load_clears_done", 128'(bus.done), 128'd0);
            wait_done();
            check("rt_lat", 128'(cyc), 128'd22);
            check("rt_pt", bus.plaintext, pt);
            hold = $urandom_range(0, 3);
            repeat (hold) tick();
            check("rt_hold_done", 128'(bus.done), 128'd1);
            check("rt_hold_pt", bus.plaintext, pt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
